// File: rtl/iic_pkg.sv
// Shared I2C definitions: FSM state encoding, ACK/NACK levels, idle-read byte.
package iic_pkg;

    localparam int unsigned BIT_CNT_W = 4;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_ADDR     = 3'd1;
    localparam logic [2:0] ST_ADDR_ACK = 3'd2;
    localparam logic [2:0] ST_WR_DATA  = 3'd3;
    localparam logic [2:0] ST_WR_ACK   = 3'd4;
    localparam logic [2:0] ST_RD_DATA  = 3'd5;
    localparam logic [2:0] ST_RD_ACK   = 3'd6;
    localparam logic [2:0] ST_IGNORE   = 3'd7;

    typedef enum logic [2:0] {
        S_IDLE     = ST_IDLE,
        S_ADDR     = ST_ADDR,
        S_ADDR_ACK = ST_ADDR_ACK,
        S_WR_DATA  = ST_WR_DATA,
        S_WR_ACK   = ST_WR_ACK,
        S_RD_DATA  = ST_RD_DATA,
        S_RD_ACK   = ST_RD_ACK,
        S_IGNORE   = ST_IGNORE
    } iic_state_e;

    localparam logic ACK_BIT  = 1'b0;
    localparam logic NACK_BIT = 1'b1;

    // Byte sent when a read finds the transmit FIFO empty
    localparam logic [7:0] IDLE_READ_BYTE = 8'hFF;

endpackage

// File: rtl/iic_slave_bus_sync.sv
// SCL/SDA synchronizers plus history flops; emits registered bus events
// (scl_rise, scl_fall, START, STOP) and the SDA level seen with them.
module iic_slave_bus_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic arst,
    input  logic scl_i,
    input  logic sda_i,
    output logic scl_rise_o,
    output logic scl_fall_o,
    output logic start_o,
    output logic stop_o,
    output logic sda_lvl_o
);

    localparam int unsigned STAGES = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

    logic [STAGES-1:0] scl_sync_q;
    logic [STAGES-1:0] sda_sync_q;
    logic              scl_hist_q;
    logic              sda_hist_q;
    logic              scl_rise_q;
    logic              scl_fall_q;
    logic              start_q;
    logic              stop_q;
    logic              sda_lvl_q;
    logic              scl_s;
    logic              sda_s;

    assign scl_s = scl_sync_q[STAGES-1];
    assign sda_s = sda_sync_q[STAGES-1];

    // Synchronizer chains reset to the idle (released) bus level
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_hist_q <= 1'b1;
            sda_hist_q <= 1'b1;
            scl_rise_q <= 1'b0;
            scl_fall_q <= 1'b0;
            start_q    <= 1'b0;
            stop_q     <= 1'b0;
            sda_lvl_q  <= 1'b1;
        end else begin
            scl_sync_q <= {scl_sync_q[STAGES-2:0], scl_i};
            sda_sync_q <= {sda_sync_q[STAGES-2:0], sda_i};
            scl_hist_q <= scl_s;
            sda_hist_q <= sda_s;
            scl_rise_q <= scl_s & ~scl_hist_q;
            scl_fall_q <= ~scl_s & scl_hist_q;
            start_q    <= scl_s & scl_hist_q & sda_hist_q & ~sda_s;
            stop_q     <= scl_s & scl_hist_q & ~sda_hist_q & sda_s;
            sda_lvl_q  <= sda_s;
        end
    end

    assign scl_rise_o = scl_rise_q;
    assign scl_fall_o = scl_fall_q;
    assign start_o    = start_q;
    assign stop_o     = stop_q;
    assign sda_lvl_o  = sda_lvl_q;

endmodule

// File: rtl/iic_slave_engine.sv
// I2C target engine: decodes START/STOP/address, ACKs its own address,
// writes received bytes to the RX FIFO and sends bytes from the TX FIFO.
// Optional clock stretching on FIFO empty/full: IIC_SLAVE_CLK_STRETCH_EN.
module iic_slave_engine
    import iic_pkg::*;
#(
    parameter logic [6:0]  SLAVE_ADDR  = 7'h50,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       arst,
    input  logic       scl_i,
    output logic       scl_o,
    output logic       scl_t,
    input  logic       sda_i,
    output logic       sda_o,
    output logic       sda_t,
    output logic [8:0] rx_data,
    output logic       rx_wr,
    input  logic       rx_full,
    input  logic [7:0] tx_data,
    output logic       tx_rd,
    input  logic       tx_empty,
    output logic       busy,
    output logic       stop_det
);

    logic scl_rise, scl_fall, start_ev, stop_ev, sda_lvl;

    iic_slave_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk        (clk),
        .arst       (arst),
        .scl_i      (scl_i),
        .sda_i      (sda_i),
        .scl_rise_o (scl_rise),
        .scl_fall_o (scl_fall),
        .start_o    (start_ev),
        .stop_o     (stop_ev),
        .sda_lvl_o  (sda_lvl)
    );

    iic_state_e           state_q,   state_d;
    logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [7:0]           shift_q,   shift_d;
    logic                 rw_q,      rw_d;
    logic                 first_q,   first_d;
    logic                 sda_q,     sda_d;
    logic                 hold_q,    hold_d;
    logic [8:0]           rx_data_q, rx_data_d;
    logic                 rx_wr_q,   rx_wr_d;
    logic                 tx_rd_q,   tx_rd_d;
    logic                 busy_q,    busy_d;
    logic                 stop_q,    stop_d;
    logic                 load_req;
    logic                 wr_req;
    logic [7:0]           addr_byte;

    assign addr_byte = {shift_q[6:0], sda_lvl};

    // State and output registers; reset releases both lines immediately
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q   <= S_IDLE;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            rw_q      <= 1'b0;
            first_q   <= 1'b0;
            sda_q     <= 1'b1;
            hold_q    <= 1'b0;
            rx_data_q <= '0;
            rx_wr_q   <= 1'b0;
            tx_rd_q   <= 1'b0;
            busy_q    <= 1'b0;
            stop_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            rw_q      <= rw_d;
            first_q   <= first_d;
            sda_q     <= sda_d;
            hold_q    <= hold_d;
            rx_data_q <= rx_data_d;
            rx_wr_q   <= rx_wr_d;
            tx_rd_q   <= tx_rd_d;
            busy_q    <= busy_d;
            stop_q    <= stop_d;
        end
    end

    // Next-state logic: STOP/START first, then per-state bit handling, then
    // the shared read-byte load and write-byte commit paths
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        rw_d      = rw_q;
        first_d   = first_q;
        sda_d     = sda_q;
        hold_d    = hold_q;
        rx_data_d = rx_data_q;
        rx_wr_d   = 1'b0;
        tx_rd_d   = 1'b0;
        busy_d    = busy_q;
        stop_d    = 1'b0;
        load_req  = 1'b0;
        wr_req    = 1'b0;

        if (stop_ev) begin
            state_d = S_IDLE;
            sda_d   = NACK_BIT;
            hold_d  = 1'b0;
            busy_d  = 1'b0;
            stop_d  = 1'b1;
        end else if (start_ev) begin
            state_d   = S_ADDR;
            bit_cnt_d = '0;
            sda_d     = NACK_BIT;
            hold_d    = 1'b0;
            first_d   = 1'b1;
        end else begin
            case (state_q)
                S_ADDR: begin
                    if (scl_rise) begin
                        shift_d   = addr_byte;
                        bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
                        if (bit_cnt_q == BIT_CNT_W'(7)) begin
                            bit_cnt_d = '0;
                            rw_d      = addr_byte[0];
                            if (addr_byte[7:1] == SLAVE_ADDR) begin
                                state_d = S_ADDR_ACK;
                                busy_d  = 1'b1;
                            end else begin
                                state_d = S_IGNORE;
                            end
                        end
                    end
                end
                S_ADDR_ACK: begin
                    if (hold_q) begin
                        load_req = 1'b1;
                    end else if (scl_fall) begin
                        if (bit_cnt_q == '0) begin
                            sda_d     = ACK_BIT;
                            bit_cnt_d = BIT_CNT_W'(1);
                        end else if (!rw_q) begin
                            sda_d     = NACK_BIT;
                            bit_cnt_d = '0;
                            state_d   = S_WR_DATA;
                        end else begin
                            load_req = 1'b1;
                        end
                    end
                end
                S_WR_DATA: begin
                    if (hold_q) begin
                        wr_req = 1'b1;
                    end else if (scl_rise) begin
                        shift_d   = addr_byte;
                        bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
                    end else if (scl_fall && bit_cnt_q == BIT_CNT_W'(8)) begin
                        wr_req = 1'b1;
                    end
                end
                S_WR_ACK: begin
                    if (scl_fall) begin
                        sda_d     = NACK_BIT;
                        bit_cnt_d = '0;
                        state_d   = S_WR_DATA;
                    end
                end
                S_RD_DATA: begin
                    if (scl_fall) begin
                        if (bit_cnt_q == BIT_CNT_W'(8)) begin
                            sda_d     = NACK_BIT;
                            bit_cnt_d = '0;
                            state_d   = S_RD_ACK;
                        end else begin
                            sda_d     = shift_q[7];
                            shift_d   = {shift_q[6:0], 1'b1};
                            bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
                        end
                    end
                end
                S_RD_ACK: begin
                    if (hold_q) begin
                        load_req = 1'b1;
                    end else if (scl_rise && bit_cnt_q == '0) begin
                        if (sda_lvl) begin
                            state_d = S_IGNORE;
                        end else begin
                            bit_cnt_d = BIT_CNT_W'(1);
                        end
                    end else if (scl_fall && bit_cnt_q == BIT_CNT_W'(1)) begin
                        load_req = 1'b1;
                    end
                end
                default: ;
            endcase

            if (load_req) begin
                if (!tx_empty) begin
                    tx_rd_d   = 1'b1;
                    sda_d     = tx_data[7];
                    shift_d   = {tx_data[6:0], 1'b1};
                    bit_cnt_d = BIT_CNT_W'(1);
                    hold_d    = 1'b0;
                    state_d   = S_RD_DATA;
                end else begin
`ifdef IIC_SLAVE_CLK_STRETCH_EN
                    sda_d  = NACK_BIT;
                    hold_d = 1'b1;
`else
                    sda_d     = IDLE_READ_BYTE[7];
                    shift_d   = {IDLE_READ_BYTE[6:0], 1'b1};
                    bit_cnt_d = BIT_CNT_W'(1);
                    state_d   = S_RD_DATA;
`endif
                end
            end

            if (wr_req) begin
                if (!rx_full) begin
                    rx_wr_d   = 1'b1;
                    rx_data_d = {first_q, shift_q};
                    first_d   = 1'b0;
                    sda_d     = ACK_BIT;
                    hold_d    = 1'b0;
                    state_d   = S_WR_ACK;
                end else begin
`ifdef IIC_SLAVE_CLK_STRETCH_EN
                    hold_d = 1'b1;
`else
                    state_d = S_IGNORE;
`endif
                end
            end
        end
    end

`ifdef IIC_SLAVE_CLK_STRETCH_EN
    assign scl_o = ~hold_q;
`else
    assign scl_o = 1'b1;
`endif

    assign scl_t    = scl_o;
    assign sda_o    = sda_q;
    assign sda_t    = sda_q;
    assign rx_data  = rx_data_q;
    assign rx_wr    = rx_wr_q;
    assign tx_rd    = tx_rd_q;
    assign busy     = busy_q;
    assign stop_det = stop_q;

endmodule

// File: tb/tb_iic_slave_engine.sv
// Bench for iic_slave_engine: bus-level I2C master model, RX scoreboard,
// TX FIFO model, directed scenarios followed by randomized transactions.
module tb_iic_slave_engine;

    localparam int Q = 8;

    logic       clk;
    logic       arst;
    logic       scl_m, sda_m;
    logic       scl_bus, sda_bus;
    logic       scl_o, scl_t, sda_o, sda_t;
    logic [8:0] rx_data;
    logic       rx_wr, rx_full;
    logic [7:0] tx_data;
    logic       tx_rd, tx_empty;
    logic       busy, stop_det;

    int tests = 0;
    int fails = 0;
    int stop_cnt = 0;
    int exp_stops = 0;
    int tx_pops = 0;
    int exp_pops = 0;

    logic [8:0] rx_exp[$];
    logic [7:0] tx_q[$];
    logic [7:0] mdl_q[$];

    assign scl_bus = scl_m & scl_o;
    assign sda_bus = sda_m & sda_o;

    iic_slave_engine dut (
        .clk      (clk),
        .arst     (arst),
        .scl_i    (scl_bus),
        .scl_o    (scl_o),
        .scl_t    (scl_t),
        .sda_i    (sda_bus),
        .sda_o    (sda_o),
        .sda_t    (sda_t),
        .rx_data  (rx_data),
        .rx_wr    (rx_wr),
        .rx_full  (rx_full),
        .tx_data  (tx_data),
        .tx_rd    (tx_rd),
        .tx_empty (tx_empty),
        .busy     (busy),
        .stop_det (stop_det)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tx_refresh();
        tx_empty = (tx_q.size() == 0);
        tx_data  = tx_empty ? 8'h00 : tx_q[0];
    endtask

    task automatic tx_push(input logic [7:0] b);
        tx_q.push_back(b);
        mdl_q.push_back(b);
        tx_refresh();
    endtask

    // Reference read: next pushed byte, or the idle byte when nothing is queued
    task automatic exp_read(output logic [7:0] b);
        if (mdl_q.size() != 0) begin
            b = mdl_q.pop_front();
            exp_pops++;
        end else begin
            b = 8'hFF;
        end
    endtask

    // Monitor: RX scoreboard, TX FIFO pops, STOP pulse counting
    always @(negedge clk) begin
        if (rx_wr) begin
            if (rx_exp.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL rx_unexpected: got %0h expected no write", rx_data);
            end else begin
                check("rx_data", 32'(rx_data), 32'(rx_exp.pop_front()));
            end
        end
        if (tx_rd) begin
            tx_pops++;
            if (tx_q.size() != 0) void'(tx_q.pop_front());
            tx_refresh();
        end
        if (stop_det) stop_cnt++;
    end

    task automatic qwait();
        repeat (Q) @(negedge clk);
    endtask

    task automatic wait_scl_high();
        int n = 0;
        while (scl_bus !== 1'b1 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (scl_bus !== 1'b1) begin
            tests++;
            fails++;
            $display("FAIL scl_wait: got scl low after %0d clk expected released", n);
        end
    endtask

    task automatic m_bit(input logic b);
        sda_m = b;
        qwait();
        scl_m = 1'b1;
        wait_scl_high();
        qwait();
        qwait();
        scl_m = 1'b0;
        qwait();
    endtask

    task automatic m_rbit(output logic b);
        sda_m = 1'b1;
        qwait();
        scl_m = 1'b1;
        wait_scl_high();
        qwait();
        b = sda_bus;
        qwait();
        scl_m = 1'b0;
        qwait();
    endtask

    task automatic m_start();
        sda_m = 1'b1;
        qwait();
        scl_m = 1'b1;
        wait_scl_high();
        qwait();
        sda_m = 1'b0;
        qwait();
        scl_m = 1'b0;
        qwait();
    endtask

    task automatic m_stop();
        sda_m = 1'b0;
        qwait();
        scl_m = 1'b1;
        wait_scl_high();
        qwait();
        sda_m = 1'b1;
        qwait();
        exp_stops++;
    endtask

    task automatic m_wbyte(input logic [7:0] b, output logic ack);
        for (int i = 7; i >= 0; i--) m_bit(b[i]);
        m_rbit(ack);
    endtask

    task automatic m_rbyte(input logic nack, output logic [7:0] b);
        logic bt;
        b = 8'h00;
        for (int i = 0; i < 8; i++) begin
            m_rbit(bt);
            b = {b[6:0], bt};
        end
        m_bit(nack);
    endtask

    task automatic do_write(input logic [7:0] addr_byte, input logic [7:0] data[$], input bit do_stop);
        logic ack;
        logic match;
        match = (addr_byte[7:1] == 7'h50) && !addr_byte[0];
        m_start();
        m_wbyte(addr_byte, ack);
        check("addr_ack_w", 32'(ack), match ? 32'd0 : 32'd1);
        check("busy_w", 32'(busy), match ? 32'd1 : 32'd0);
        if (match) begin
            for (int i = 0; i < data.size(); i++) begin
                rx_exp.push_back({1'(i == 0), data[i]});
                m_wbyte(data[i], ack);
                check("data_ack", 32'(ack), 32'd0);
            end
        end
        if (do_stop) m_stop();
    endtask

    task automatic do_read(input logic [7:0] addr_byte, input int n);
        logic ack;
        logic match;
        logic [7:0] e, got;
        match = (addr_byte[7:1] == 7'h50) && addr_byte[0];
        m_start();
        m_wbyte(addr_byte, ack);
        check("addr_ack_r", 32'(ack), match ? 32'd0 : 32'd1);
        check("busy_r", 32'(busy), match ? 32'd1 : 32'd0);
        if (match) begin
            for (int i = 0; i < n; i++) begin
                exp_read(e);
                m_rbyte(1'(i == n - 1), got);
                check("rd_byte", 32'(got), 32'(e));
            end
        end
        m_stop();
    endtask

    task automatic end_checks(input string tag);
        check({tag, "_stops"}, 32'(stop_cnt), 32'(exp_stops));
        check({tag, "_pops"}, 32'(tx_pops), 32'(exp_pops));
        check({tag, "_busy_idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        logic [7:0] d[$];
        logic       ack;
        logic [6:0] a7;
        int         n, fill;
        bit         is_read, match;

        arst    = 1'b1;
        scl_m   = 1'b1;
        sda_m   = 1'b1;
        rx_full = 1'b0;
        tx_refresh();
        repeat (3) @(negedge clk);
        check("rst_sda_o", 32'(sda_o), 32'd1);
        check("rst_scl_o", 32'(scl_o), 32'd1);
        check("rst_sda_t", 32'(sda_t), 32'd1);
        check("rst_rx_wr", 32'(rx_wr), 32'd0);
        check("rst_tx_rd", 32'(tx_rd), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_stop_det", 32'(stop_det), 32'd0);
        check("rst_rx_data", 32'(rx_data), 32'd0);
        arst = 1'b0;
        qwait();

        // Two-byte write to our address
        d = '{8'h12, 8'h34};
        do_write(8'hA0, d, 1'b1);
        end_checks("wr2");

        // Foreign address: NACK, no FIFO traffic
        d.delete();
        do_write(8'hA2, d, 1'b1);
        end_checks("nomatch");

        // Two-byte read with master ACK then NACK
        tx_push(8'h5A);
        tx_push(8'hC3);
        do_read(8'hA1, 2);
        end_checks("rd2");

        // Read with the transmit FIFO empty
`ifdef IIC_SLAVE_CLK_STRETCH_EN
        mdl_q.push_back(8'h77);
        fork
            begin
                int k = 0;
                while (scl_o !== 1'b0 && k < 5000) begin @(negedge clk); k++; end
                repeat (100) @(negedge clk);
                check("stretch_rd_scl", 32'(scl_o), 32'd0);
                tx_q.push_back(8'h77);
                tx_refresh();
            end
        join_none
`endif
        do_read(8'hA1, 1);
        end_checks("rd_empty");

        // Receive FIFO full at the second byte
        m_start();
        m_wbyte(8'hA0, ack);
        check("full_addr_ack", 32'(ack), 32'd0);
        rx_exp.push_back(9'h121);
        m_wbyte(8'h21, ack);
        check("full_b1_ack", 32'(ack), 32'd0);
        rx_full = 1'b1;
`ifdef IIC_SLAVE_CLK_STRETCH_EN
        rx_exp.push_back(9'h043);
        fork
            begin
                int k = 0;
                while (scl_o !== 1'b0 && k < 5000) begin @(negedge clk); k++; end
                repeat (100) @(negedge clk);
                check("stretch_wr_scl", 32'(scl_o), 32'd0);
                rx_full = 1'b0;
            end
        join_none
        m_wbyte(8'h43, ack);
        check("full_b2_ack", 32'(ack), 32'd0);
`else
        m_wbyte(8'h43, ack);
        check("full_b2_ack", 32'(ack), 32'd1);
        rx_full = 1'b0;
`endif
        m_stop();
        end_checks("rx_full");

        // Write then repeated START into a read
        d = '{8'h11};
        do_write(8'hA0, d, 1'b0);
        tx_push(8'h3C);
        do_read(8'hA1, 1);
        end_checks("rep_start");

        // Asynchronous reset while the target drives the address ACK
        m_start();
        for (int i = 7; i >= 0; i--) m_bit(1'((8'hA0 >> i) & 8'h01));
        sda_m = 1'b1;
        repeat (6) @(negedge clk);
        check("ack_before_rst", 32'(sda_o), 32'd0);
        #2 arst = 1'b1;
        #1;
        check("arst_sda_o", 32'(sda_o), 32'd1);
        check("arst_scl_o", 32'(scl_o), 32'd1);
        check("arst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        arst = 1'b0;
        // Without a new START the target must stay idle and not ACK
        m_wbyte(8'hA0, ack);
        check("post_rst_idle", 32'(ack), 32'd1);
        m_stop();
        end_checks("arst");

        // Randomized transactions
        for (int it = 0; it < 12; it++) begin
            is_read = 1'($urandom_range(0, 1));
            match   = ($urandom_range(0, 3) != 0);
            a7      = match ? 7'h50 : (7'h50 ^ 7'($urandom_range(1, 127)));
            n       = $urandom_range(1, 3);
            if (is_read) begin
`ifdef IIC_SLAVE_CLK_STRETCH_EN
                fill = n;
`else
                fill = $urandom_range(0, n);
`endif
                if (match) for (int k = 0; k < fill; k++) tx_push(8'($urandom));
                do_read({a7, 1'b1}, n);
            end else begin
                d.delete();
                for (int k = 0; k < n; k++) d.push_back(8'($urandom));
                do_write({a7, 1'b0}, d, 1'b1);
            end
        end
        end_checks("rand");

        check("rx_pending", 32'(rx_exp.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
